// File: rtl/ib_fill_ctrl_pkg.sv
// Shared definitions for the instruction-buffer fill path: entry layout, fault flag positions,
// reset PC and the fill controller state encoding.
package ib_fill_ctrl_pkg;

   localparam int unsigned ENTRY_W     = 71;
   localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
   localparam int unsigned ACK_TIMEOUT = 255;

   localparam int unsigned INSTR_LSB    = 0;
   localparam int unsigned PC_LSB       = 32;
   localparam int unsigned MISALIGN_BIT = 64;
   localparam int unsigned BUS_ERR_BIT  = 65;
   localparam int unsigned RSVD_BIT     = 66;
   localparam int unsigned EPOCH_LSB    = 67;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StPushLo = 3'd2,
      StPushHi = 3'd3,
      StDrop   = 3'd4,
      StExc    = 3'd5,
      StHalt   = 3'd6
   } fill_state_e;

   function automatic logic [ENTRY_W-1:0] pack_entry(input logic [3:0]  epoch,
                                                     input logic        bus_err,
                                                     input logic        misaligned,
                                                     input logic [31:0] pc,
                                                     input logic [31:0] instr);
      return {epoch, 1'b0, bus_err, misaligned, pc, instr};
   endfunction

endpackage

// File: rtl/ib_fill_ctrl_timeout.sv
// Saturating 8-bit wait counter used to bound how long a fetch request may wait for its ack.
module ib_fill_ctrl_timeout #(
   parameter int unsigned Max = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam logic [7:0] MaxCnt = 8'(Max);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (inc_i && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/ib_fill_ctrl.sv
// Fetch-side writer for the instruction buffer: requests 64-bit packets, splits them into
// two entries, and handles redirects, in-flight response drop and fetch faults.
module ib_fill_ctrl
   import ib_fill_ctrl_pkg::*;
#(
   parameter logic [31:0] ResetPc    = RESET_PC,
   parameter int unsigned AckTimeout = ACK_TIMEOUT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic [31:0]        flush_pc_i,
   output logic               if_req_o,
   output logic [31:0]        if_addr_o,
   input  logic               if_ack_i,
   input  logic [63:0]        if_rdata_i,
   input  logic               if_err_i,
   output logic               ib_wen_o,
   output logic [ENTRY_W-1:0] ib_wdata_o,
   input  logic               ib_full_i
);

   fill_state_e state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  epoch_q, epoch_d;
   logic [63:0] rdata_q, rdata_d;
   logic        mis_q, mis_d;
   logic        berr_q, berr_d;

   logic        expired;
   logic        cnt_inc;
   logic        cnt_clr;
   logic        launch;
   logic [31:0] launch_pc;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      epoch_d   = epoch_q;
      rdata_d   = rdata_q;
      mis_d     = mis_q;
      berr_d    = berr_q;
      launch    = 1'b0;
      launch_pc = pc_q;

      if (flush_i) begin
         pc_d      = flush_pc_i;
         epoch_d   = epoch_q + 4'd1;
         rdata_d   = 64'd0;
         mis_d     = 1'b0;
         berr_d    = 1'b0;
         launch_pc = flush_pc_i;
         // A request still outstanding must be waited out before a new one may be issued.
         if ((state_q == StFetch || state_q == StDrop) && !if_ack_i && !expired) begin
            state_d = StDrop;
         end else begin
            launch = 1'b1;
         end
      end else begin
         case (state_q)
            StIdle: launch = 1'b1;
            StFetch: begin
               if (if_ack_i) begin
                  rdata_d = if_rdata_i;
                  if (if_err_i) begin
                     berr_d  = 1'b1;
                     state_d = StExc;
                  end else begin
                     state_d = pc_q[2] ? StPushHi : StPushLo;
                  end
               end else if (expired) begin
                  berr_d  = 1'b1;
                  state_d = StExc;
               end
            end
            StPushLo: begin
               if (!ib_full_i) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = StPushHi;
               end
            end
            StPushHi: begin
               if (!ib_full_i) begin
                  pc_d      = pc_q + 32'd4;
                  launch_pc = pc_q + 32'd4;
                  launch    = 1'b1;
               end
            end
            StDrop: begin
               if (if_ack_i || expired) begin
                  launch = 1'b1;
               end
            end
            StExc: begin
               if (!ib_full_i) begin
                  state_d = StHalt;
               end
            end
            default: ;
         endcase
      end

      if (launch) begin
         if (launch_pc[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = StExc;
         end else begin
            addr_d  = {launch_pc[31:3], 3'b000};
            state_d = StFetch;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pc_q    <= ResetPc;
         addr_q  <= ResetPc;
         epoch_q <= 4'd0;
         rdata_q <= 64'd0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         epoch_q <= epoch_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   // Counting spans FETCH and a following DROP: both wait on the same outstanding request.
   assign cnt_inc = (state_q == StFetch) || (state_q == StDrop);
   assign cnt_clr = if_ack_i || expired || !((state_d == StFetch) || (state_d == StDrop));

   ib_fill_ctrl_timeout #(
      .Max (AckTimeout)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .expired_o (expired)
   );

   always_comb begin
      ib_wen_o   = 1'b0;
      ib_wdata_o = '0;
      case (state_q)
         StPushLo: begin
            ib_wen_o   = 1'b1;
            ib_wdata_o = pack_entry(epoch_q, 1'b0, 1'b0, pc_q, rdata_q[31:0]);
         end
         StPushHi: begin
            ib_wen_o   = 1'b1;
            ib_wdata_o = pack_entry(epoch_q, 1'b0, 1'b0, pc_q, rdata_q[63:32]);
         end
         StExc: begin
            ib_wen_o   = 1'b1;
            ib_wdata_o = pack_entry(epoch_q, berr_q, mis_q, pc_q, 32'd0);
         end
         default: ;
      endcase
      if (flush_i) begin
         ib_wen_o = 1'b0;
      end
   end

   assign if_req_o  = (state_q == StFetch) || (state_q == StDrop);
   assign if_addr_o = addr_q;

endmodule

// File: tb/tb_ib_fill_ctrl.sv
// Directed bench for ib_fill_ctrl: packet unpacking, stalls, redirects, faults and reset.
module tb_ib_fill_ctrl;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [31:0] flush_pc;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [63:0] if_rdata;
   logic        if_err;
   logic        ib_wen;
   logic [70:0] ib_wdata;
   logic        ib_full;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   int nreq;
   int guard;
   logic got;

   ib_fill_ctrl dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .flush_pc_i (flush_pc),
      .if_req_o   (if_req),
      .if_addr_o  (if_addr),
      .if_ack_i   (if_ack),
      .if_rdata_i (if_rdata),
      .if_err_i   (if_err),
      .ib_wen_o   (ib_wen),
      .ib_wdata_o (ib_wdata),
      .ib_full_i  (ib_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ib_wen && !ib_full) n_acc <= n_acc + 1;
   end

   function automatic logic [70:0] ent(input logic [3:0] ep, input logic berr, input logic mis,
                                       input logic [31:0] pc, input logic [31:0] ins);
      return {ep, 1'b0, berr, mis, pc, ins};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_e(input string tag, input logic [70:0] obs, input logic [70:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = 32'd0; if_ack = 1'b0; if_rdata = 64'd0;
      if_err = 1'b0; ib_full = 1'b0;
      tick(); tick(); settle();
      chk_b("rst_req", if_req, 1'b0);
      chk_w("rst_addr", if_addr, 32'hBFC0_0000);
      chk_b("rst_wen", ib_wen, 1'b0);
      chk_e("rst_wdata", ib_wdata, 71'd0);

      // 1: first fetch, ack on the fourth FETCH cycle
      rst = 1'b0; settle();
      chk_b("t1_idle_req", if_req, 1'b0);
      tick(); settle();
      chk_b("t1_req", if_req, 1'b1);
      chk_w("t1_addr", if_addr, 32'hBFC0_0000);
      tick(); settle();
      tick(); settle();
      tick(); if_ack = 1'b1; if_rdata = 64'h2222_2222_1111_1111; settle();
      chk_b("t1_req_held", if_req, 1'b1);
      tick(); if_ack = 1'b0; settle();
      chk_b("t1_wen_lo", ib_wen, 1'b1);
      chk_e("t1_entry_lo", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_0000, 32'h1111_1111));
      tick(); settle();
      chk_e("t1_entry_hi", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_0004, 32'h2222_2222));
      tick(); settle();
      chk_w("t1_next_addr", if_addr, 32'hBFC0_0008);
      chk_b("t1_wen_off", ib_wen, 1'b0);
      chk_w("t1_count", 32'(n_acc), 32'd2);

      // 2: ib_full stall during PUSH_HI
      if_ack = 1'b1; if_rdata = 64'h4444_4444_3333_3333; settle();
      tick(); if_ack = 1'b0; settle();
      chk_e("t2_entry_lo", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_0008, 32'h3333_3333));
      tick(); ib_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk_b("t2_stall_wen", ib_wen, 1'b1);
         chk_e("t2_stall_entry", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_000C, 32'h4444_4444));
         tick();
      end
      ib_full = 1'b0; settle();
      chk_e("t2_release_entry", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_000C, 32'h4444_4444));
      tick(); settle();
      chk_w("t2_next_addr", if_addr, 32'hBFC0_0010);
      chk_b("t2_wen_off", ib_wen, 1'b0);
      chk_w("t2_count", 32'(n_acc), 32'd4);

      // 3: redirect while the request is pending
      flush = 1'b1; flush_pc = 32'h0000_1004; settle();
      chk_b("t3_flush_wen", ib_wen, 1'b0);
      tick(); flush = 1'b0; settle();
      chk_b("t3_drop_req", if_req, 1'b1);
      chk_w("t3_drop_addr", if_addr, 32'hBFC0_0010);
      tick(); if_ack = 1'b1; if_rdata = 64'h9999_9999_8888_8888; settle();
      chk_w("t3_drop_addr2", if_addr, 32'hBFC0_0010);
      tick(); if_ack = 1'b0; settle();
      chk_w("t3_new_addr", if_addr, 32'h0000_1000);
      chk_b("t3_no_stale_wen", ib_wen, 1'b0);
      if_ack = 1'b1; if_rdata = 64'h6666_6666_5555_5555; settle();
      tick(); if_ack = 1'b0; settle();
      chk_b("t3_wen", ib_wen, 1'b1);
      chk_e("t3_entry", ib_wdata, ent(4'd1, 1'b0, 1'b0, 32'h0000_1004, 32'h6666_6666));
      tick(); settle();
      chk_w("t3_next_addr", if_addr, 32'h0000_1008);
      chk_w("t3_count", 32'(n_acc), 32'd5);

      // 4: flush coincident with ack
      flush = 1'b1; flush_pc = 32'h0000_2000; if_ack = 1'b1;
      if_rdata = 64'h7777_7777_7777_7777; settle();
      tick(); flush = 1'b0; if_ack = 1'b0; settle();
      chk_b("t4_req", if_req, 1'b1);
      chk_w("t4_addr", if_addr, 32'h0000_2000);
      chk_b("t4_wen_off", ib_wen, 1'b0);
      if_ack = 1'b1; if_rdata = 64'hBBBB_BBBB_AAAA_AAAA; settle();
      tick(); if_ack = 1'b0; settle();
      chk_w("t4_count", 32'(n_acc), 32'd5);
      chk_e("t4_entry_lo", ib_wdata, ent(4'd2, 1'b0, 1'b0, 32'h0000_2000, 32'hAAAA_AAAA));
      tick(); settle();
      chk_e("t4_entry_hi", ib_wdata, ent(4'd2, 1'b0, 1'b0, 32'h0000_2004, 32'hBBBB_BBBB));
      tick(); settle();
      chk_w("t4_next_addr", if_addr, 32'h0000_2008);

      // 5: bus error response
      if_ack = 1'b1; if_err = 1'b1; if_rdata = 64'h1234_5678_9ABC_DEF0; settle();
      tick(); if_ack = 1'b0; if_err = 1'b0; settle();
      chk_b("t5_wen", ib_wen, 1'b1);
      chk_e("t5_entry", ib_wdata, ent(4'd2, 1'b1, 1'b0, 32'h0000_2008, 32'd0));
      tick(); settle();
      chk_b("t5_halt_req", if_req, 1'b0);
      chk_b("t5_halt_wen", ib_wen, 1'b0);
      tick(); tick(); tick(); settle();
      chk_b("t5_halt_req_late", if_req, 1'b0);
      chk_w("t5_count", 32'(n_acc), 32'd8);

      // 6: misaligned redirect, ack timeout, reset mid-push
      flush = 1'b1; flush_pc = 32'h0000_0002; settle();
      tick(); flush = 1'b0; settle();
      chk_b("t6_mis_req", if_req, 1'b0);
      chk_b("t6_mis_wen", ib_wen, 1'b1);
      chk_e("t6_mis_entry", ib_wdata, ent(4'd3, 1'b0, 1'b1, 32'h0000_0002, 32'd0));
      tick(); settle();
      chk_b("t6_mis_halt", ib_wen, 1'b0);
      flush = 1'b1; flush_pc = 32'h0000_3000; settle();
      tick(); flush = 1'b0; settle();
      chk_w("t6_to_addr", if_addr, 32'h0000_3000);
      nreq = 0; got = 1'b0; guard = 0;
      while (!got && guard < 400) begin
         if (ib_wen) begin
            got = 1'b1;
         end else begin
            if (if_req) nreq++;
            tick(); settle();
            guard++;
         end
      end
      chk_b("t6_to_seen", got, 1'b1);
      chk_b("t6_to_len", (nreq >= 255) && (nreq <= 256), 1'b1);
      chk_e("t6_to_entry", ib_wdata, ent(4'd4, 1'b1, 1'b0, 32'h0000_3000, 32'd0));
      tick(); settle();
      flush = 1'b1; flush_pc = 32'h0000_4000; settle();
      tick(); flush = 1'b0; if_ack = 1'b1; if_rdata = 64'hDDDD_DDDD_CCCC_CCCC; settle();
      tick(); if_ack = 1'b0; settle();
      chk_e("t6_push_entry", ib_wdata, ent(4'd5, 1'b0, 1'b0, 32'h0000_4000, 32'hCCCC_CCCC));
      rst = 1'b1; settle();
      chk_b("t6_rst_wen", ib_wen, 1'b0);
      chk_e("t6_rst_wdata", ib_wdata, 71'd0);
      chk_b("t6_rst_req", if_req, 1'b0);
      chk_w("t6_rst_addr", if_addr, 32'hBFC0_0000);
      tick(); rst = 1'b0; settle();
      tick(); settle();
      chk_b("t6_refetch_req", if_req, 1'b1);
      chk_w("t6_refetch_addr", if_addr, 32'hBFC0_0000);
      if_ack = 1'b1; if_rdata = 64'hFFFF_0000_0000_FFFF; settle();
      tick(); if_ack = 1'b0; settle();
      chk_e("t6_refetch_entry", ib_wdata, ent(4'd0, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0000_FFFF));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
